// File: rtl/mem_display_pkg.sv
// Shared types and seven-segment constants for the memory display scanner.
package mem_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } state_e;

  // Common-anode, active-low, dp off: bit7=dp, bits6..0=gfedcba
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import mem_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/mem_display_scanner.sv
// Fetches one memory word over a req/ack port and scans it as hex onto a 7-seg bank.
// Define MEM_DISPLAY_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module mem_display_scanner
  import mem_display_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_en,
  input  logic [ADDR_W-1:0] out_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        show_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic [PreW-1:0]   presc_q;
  logic [IdxW-1:0]   idx_q;
  logic              presc_tc;
  logic              frame_wrap;
  state_e            state_q;
  logic [TmoW-1:0]   tmo_q;
  logic [DATA_W-1:0] shadow_q;
  logic              valid_q;
  logic [3:0]        nibble;
  logic [7:0]        seg_pat;
  logic              blank;

  assign presc_tc   = (presc_q == PreLast);
  assign frame_wrap = presc_tc && (idx_q == IdxLast);
  assign busy       = (state_q == StReq);

  // Free-running scan, independent of the read FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_tc) begin
      presc_q <= '0;
      idx_q   <= frame_wrap ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      tmo_q    <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (memread_en) begin
            state_q  <= StReq;
            mem_req  <= 1'b1;
            mem_addr <= out_addr;
            tmo_q    <= '0;
          end
        end
        StReq: begin
          if (mem_ack) begin
            state_q  <= StHold;
            mem_req  <= 1'b0;
            shadow_q <= mem_rdata;
            valid_q  <= 1'b1;
            err      <= 1'b0;
          end else if (tmo_q == TmoLast) begin
            // Without a word ever captured there is nothing to hold on display
            state_q <= valid_q ? StHold : StIdle;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StHold: begin
          if (frame_wrap && memread_en) begin
            state_q  <= StReq;
            mem_req  <= 1'b1;
            mem_addr <= out_addr;
            tmo_q    <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    nibble = shadow_q[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) nibble = shadow_q[4*i +: 4];
    end
  end

`ifdef MEM_DISPLAY_BLANK_EN
  logic [IdxW-1:0] lead_idx;

  always_comb begin
    lead_idx = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (shadow_q[4*i +: 4] != 4'h0) lead_idx = IdxW'(i);
    end
  end

  assign blank = (idx_q > lead_idx);
`else
  assign blank = 1'b0;
`endif

  seg7_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (seg_pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '1;
      show_data <= SEG_BLANK;
    end else begin
      sel       <= ~(DIGITS'(1) << idx_q);
      show_data <= blank ? SEG_BLANK : seg_pat;
    end
  end

endmodule

// File: tb/tb_mem_display_scanner.sv
// Scoreboard bench for mem_display_scanner: random reads against a behavioural display model.
module tb_mem_display_scanner;

  localparam int DIGITS = 8;
  localparam int RD     = 4;
  localparam int TMO    = 15;
  localparam int FRAME  = DIGITS * RD;
  localparam logic [7:0] HEX_LUT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82,
                                          8'hF8, 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1,
                                          8'h86, 8'h8E};

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          delay;     // -1: never acknowledge
    bit          at_wrap;   // request must start on a frame wrap
    bit          wrap_ack;  // also verify digit 0 right after the ack
    bit          abort;     // request is killed by reset
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread_en = 1'b0;
  logic [7:0]  out_addr = '0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  sel;
  logic [7:0]  show_data;
  logic        busy;
  logic        err;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          inject_req = 0;
  bit          disp_chk = 1'b0;
  logic [31:0] model_word;
  logic        model_err;
  txn_t        exp_q[$];

  mem_display_scanner #(
    .DIGITS      (DIGITS),
    .DATA_W      (32),
    .ADDR_W      (8),
    .REFRESH_DIV (RD),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memread_en (memread_en),
    .out_addr   (out_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .sel        (sel),
    .show_data  (show_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan position is pure arithmetic on this
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_pat(input logic [31:0] w, input int d);
    logic [31:0] upper;
    upper = w >> (4 * d);
`ifdef MEM_DISPLAY_BLANK_EN
    if (d != 0 && upper == 0) return 8'hFF;
`endif
    return HEX_LUT[upper[3:0]];
  endfunction

  function automatic txn_t mk(input logic [7:0] a, input logic [31:0] d, input int dly,
                              input bit aw, input bit wa, input bit ab);
    txn_t t;
    t.addr = a; t.data = d; t.delay = dly; t.at_wrap = aw; t.wrap_ack = wa; t.abort = ab;
    return t;
  endfunction

  // Display monitor: active only while the stimulus declares the shown word stable
  initial begin : disp_mon
    int d;
    logic [7:0] es;
    forever begin
      @(negedge clk);
      if (disp_chk && !rst) begin
        check("idle_req", mem_req, 1'b0);
        if (cyc == 0) begin
          check("sel_pre", sel, 8'hFF);
          check("seg_pre", show_data, 8'hFF);
        end else begin
          d  = ((cyc - 1) / RD) % DIGITS;
          es = 8'h01 << d;
          es = ~es;
          check("sel", sel, es);
          check("seg", show_data, exp_pat(model_word, d));
        end
      end
    end
  end

  // Memory responder and transaction scoreboard; owns the model word and error flag
  initial begin : mem_model
    txn_t t;
    int   hi;
    bit   acked;
    int   inj_seen;
    inj_seen = 0; mem_ack = 1'b0; mem_rdata = '0; model_word = '0; model_err = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (rst) begin
        model_word = '0; model_err = 1'b0;
      end else if (inj_seen != inject_req) begin
        inj_seen = inject_req; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      end else if (mem_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", mem_req, 1'b0);
          hi = 0;
          while (mem_req && hi < 64) begin @(negedge clk); hi++; end
        end else begin
          t = exp_q.pop_front();
          if (t.at_wrap) check("req_at_wrap", cyc % FRAME, 0);
          hi = 0; acked = 1'b0;
          while (mem_req && !rst && hi < TMO + 40) begin
            hi++;
            check("req_addr", mem_addr, t.addr);
            check("busy_req", busy, 1'b1);
            if (hi == t.delay + 1) begin
              mem_ack = 1'b1; mem_rdata = t.data; acked = 1'b1;
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
          end
          if (t.abort) begin
            check("abort_by_rst", rst, 1'b1);
            model_word = '0; model_err = 1'b0;
          end else begin
            check("req_len", hi, acked ? t.delay + 1 : TMO);
            if (acked) begin model_word = t.data; model_err = 1'b0; end
            else model_err = 1'b1;
            if (t.wrap_ack) begin
              @(negedge clk);
              check("wrap_sel", sel, 8'hFE);
              check("wrap_seg", show_data, exp_pat(t.data, 0));
            end
          end
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_sel"}, sel, 8'hFF);
    check({tag, "_seg"}, show_data, 8'hFF);
    check({tag, "_req"}, mem_req, 1'b0);
    check({tag, "_addr"}, mem_addr, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic wait_req(input logic level, input int limit, input string name);
    int w;
    w = 0;
    while (mem_req !== level && w < limit) begin @(negedge clk); w++; end
    check(name, mem_req, level);
  endtask

  task automatic wait_drain(input int limit);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < limit) begin @(negedge clk); w++; end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic settle_and_show();
    repeat (2) @(negedge clk);
    check("err_after", err, model_err);
    check("busy_after", busy, 1'b0);
    disp_chk = 1'b1;
    repeat (FRAME + 2) @(negedge clk);
    disp_chk = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] d, input int dly,
                         input bit aw);
    exp_q.push_back(mk(a, d, dly, aw, 1'b0, 1'b0));
    @(negedge clk);
    out_addr = a; memread_en = 1'b1;
    wait_req(1'b1, 100, "req_start");
    memread_en = 1'b0;
    out_addr = $urandom;  // must not disturb the latched address
    wait_req(1'b0, TMO + 45, "req_end");
    settle_and_show();
  endtask

  initial begin : stim
    logic [31:0] d;
    logic [7:0]  a;
    int          dly;
    int          w;
    txn_t        t;
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b0;
    disp_chk = 1'b1;
    repeat (40) @(negedge clk);
    disp_chk = 1'b0;

    do_read(8'h10, 32'h1234_ABCD, 3, 1'b0);

    // Auto-refresh: address change during a read lands on the next frame wrap
    exp_q.push_back(mk(8'h10, $urandom, 1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h20, 32'h0000_0005, 2, 1'b1, 1'b0, 1'b0));
    out_addr = 8'h10; memread_en = 1'b1;
    wait_req(1'b1, 100, "auto_start");
    out_addr = 8'h20;
    wait_drain(200);
    memread_en = 1'b0;
    wait_req(1'b0, TMO + 45, "auto_end");
    settle_and_show();

    do_read($urandom, $urandom, -1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      d = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) d = '0;
      dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 6));
      do_read($urandom, d, dly, 1'b1);
    end
    do_read($urandom, $urandom, -1, 1'b1);

    // Reset in the middle of an unanswered request
    a = $urandom;
    exp_q.push_back(mk(a, '0, -1, 1'b1, 1'b0, 1'b1));
    out_addr = a; memread_en = 1'b1;
    wait_req(1'b1, 100, "abort_start");
    memread_en = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    inject_req++;
    repeat (3) @(negedge clk);
    check("late_ack_req", mem_req, 1'b0);
    check("late_ack_err", err, 1'b0);
    settle_and_show();

    // Ack coincides with a frame wrap, memread_en held high
    w = 0;
    while (cyc % FRAME != FRAME - 8 && w < 2 * FRAME) begin @(negedge clk); w++; end
    t = mk($urandom, $urandom, 6, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(t);
    exp_q.push_back(mk(t.addr, $urandom, 1, 1'b1, 1'b0, 1'b0));
    out_addr = t.addr; memread_en = 1'b1;
    wait_drain(200);
    memread_en = 1'b0;
    wait_req(1'b0, TMO + 45, "wrap_end");
    settle_and_show();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
